// File: rtl/multi_coupling_estimator_if.sv
// Bus interface for multi_coupling_estimator: beat stream in, per-frame result out.
interface multi_coupling_estimator_if #(
   parameter int unsigned PHASE_W = 6,
   parameter int unsigned COEF_W  = 4,
   parameter int unsigned OUT_W   = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_last;
   logic [PHASE_W-1:0]        self_phase;
   logic [PHASE_W-1:0]        coupling_phase;
   logic signed [COEF_W-1:0]  coupling_factor;
   logic                      out_valid;
   logic signed [OUT_W-1:0]   out_gradient;
   logic signed [OUT_W-1:0]   out_Hamiltonian;
   logic                      overflow_flag;
   logic                      sat_flag;

   modport master (
      output in_valid, in_last, self_phase, coupling_phase, coupling_factor,
      input  in_ready, out_valid, out_gradient, out_Hamiltonian, overflow_flag, sat_flag
   );

   modport slave (
      input  in_valid, in_last, self_phase, coupling_phase, coupling_factor,
      output in_ready, out_valid, out_gradient, out_Hamiltonian, overflow_flag, sat_flag
   );
endinterface

// File: rtl/multi_coupling_estimator.sv
// Streaming multi-neighbour coupling estimator for the oscillator-Ising datapath.
// Accumulates J*S(d) and -J*C(d) over a frame of beats, one result per frame.
// Optional: define MULTI_COUPLING_ESTIMATOR_SAT_EN for saturating accumulation.
module multi_coupling_estimator #(
   parameter int unsigned PHASE_W   = 6,
   parameter int unsigned COEF_W    = 4,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned MAX_NEIGH = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ena,
   multi_coupling_estimator_if.slave        bus
);
   localparam int unsigned SW = PHASE_W + 2;
   localparam int unsigned PW = COEF_W + SW + 1;
   localparam int unsigned CW = $clog2(MAX_NEIGH + 1);
   localparam logic [PHASE_W-1:0] Q_U  = PHASE_W'(1) << (PHASE_W - 2);
   localparam logic [PHASE_W-1:0] Q3_U = PHASE_W'(3) << (PHASE_W - 2);
   localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_CLOSE} state_e;

   // Triangle-wave nonlinearity over one phase period, range -Q..Q.
   function automatic logic signed [SW-1:0] tri_wave(input logic [PHASE_W-1:0] x);
      logic signed [SW-1:0] xs;
      logic signed [SW-1:0] q;
      xs = signed'(SW'(x));
      q  = signed'(SW'(Q_U));
      if (x < Q_U)       tri_wave = xs;
      else if (x < Q3_U) tri_wave = (q <<< 1) - xs;
      else               tri_wave = xs - (q <<< 2);
   endfunction

   // Accumulator add; returns {clamped, sum}.
   function automatic logic [OUT_W:0] acc_add(input logic signed [OUT_W-1:0] a,
                                              input logic signed [OUT_W-1:0] b);
`ifdef MULTI_COUPLING_ESTIMATOR_SAT_EN
      logic signed [OUT_W:0] s;
      s = {a[OUT_W-1], a} + {b[OUT_W-1], b};
      if (s[OUT_W] != s[OUT_W-1]) acc_add = {1'b1, (s[OUT_W] ? ACC_MIN : ACC_MAX)};
      else                        acc_add = {1'b0, s[OUT_W-1:0]};
`else
      logic signed [OUT_W-1:0] s;
      s = a + b;
      acc_add = {1'b0, s};
`endif
   endfunction

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [PHASE_W-1:0]       self_q;
   logic                     ovf_q;
   logic                     acc_c, first_c, at_max_c, close_c, force_c;
   logic [PHASE_W-1:0]       self_eff_c, d_c;

   logic                     s1_vld_q, s1_first_q, s1_last_q;
   logic signed [SW-1:0]     s1_s_q, s1_c_q;
   logic signed [COEF_W-1:0] s1_j_q;

   logic signed [PW-1:0]     gp_c, hp_c;
   logic signed [OUT_W-1:0]  g_c, h_c;
   logic [OUT_W:0]           gsum_c, hsum_c;
   logic signed [OUT_W-1:0]  grad_q, ham_q;
   logic                     s2_last_q, sat_q;

   logic                     out_valid_q;
   logic signed [OUT_W-1:0]  out_grad_q, out_ham_q;

   assign bus.in_ready = ena & ~reset;
   assign acc_c        = bus.in_valid & bus.in_ready;
   assign first_c      = (state_q != ST_ACCUM);
   assign at_max_c     = !first_c && (cnt_q == CW'(MAX_NEIGH - 1));
   assign close_c      = bus.in_last | at_max_c;
   assign force_c      = acc_c & at_max_c & ~bus.in_last;
   assign self_eff_c   = first_c ? bus.self_phase : self_q;
   assign d_c          = self_eff_c - bus.coupling_phase;

   // Frame FSM next-state: tracks beat count and the closing beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLOSE) state_d = ST_IDLE;
      if (acc_c) begin
         state_d = close_c ? ST_CLOSE : ST_ACCUM;
         cnt_d   = first_c ? CW'(1) : cnt_q + CW'(1);
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stage 1: latch self phase and register S(d), C(d), J with frame markers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_s_q     <= '0;
         s1_c_q     <= '0;
         s1_j_q     <= '0;
         self_q     <= '0;
         ovf_q      <= 1'b0;
      end else if (ena) begin
         s1_vld_q <= acc_c;
         ovf_q    <= ovf_q | force_c;
         if (acc_c) begin
            s1_first_q <= first_c;
            s1_last_q  <= close_c;
            s1_s_q     <= tri_wave(d_c);
            s1_c_q     <= tri_wave(d_c + Q_U);
            s1_j_q     <= bus.coupling_factor;
            self_q     <= self_eff_c;
         end
      end
   end

   // Per-beat gradient and Hamiltonian terms plus accumulator sums.
   always_comb begin
      gp_c   = PW'(s1_j_q) * PW'(s1_s_q);
      hp_c   = -(PW'(s1_j_q) * PW'(s1_c_q));
      g_c    = OUT_W'(gp_c);
      h_c    = OUT_W'(hp_c);
      gsum_c = acc_add(grad_q, g_c);
      hsum_c = acc_add(ham_q, h_c);
   end

   // Stage 2: load on the first beat of a frame, add on later beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         grad_q    <= '0;
         ham_q     <= '0;
         s2_last_q <= 1'b0;
         sat_q     <= 1'b0;
      end else if (ena) begin
         s2_last_q <= s1_vld_q & s1_last_q;
         if (s1_vld_q) begin
            if (s1_first_q) begin
               grad_q <= g_c;
               ham_q  <= h_c;
            end else begin
               grad_q <= gsum_c[OUT_W-1:0];
               ham_q  <= hsum_c[OUT_W-1:0];
               sat_q  <= sat_q | gsum_c[OUT_W] | hsum_c[OUT_W];
            end
         end
      end
   end

   // Stage 3: publish the closed frame's result with a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_grad_q  <= '0;
         out_ham_q   <= '0;
      end else if (ena) begin
         out_valid_q <= s2_last_q;
         if (s2_last_q) begin
            out_grad_q <= grad_q;
            out_ham_q  <= ham_q;
         end
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.out_gradient    = out_grad_q;
   assign bus.out_Hamiltonian = out_ham_q;
   assign bus.overflow_flag   = ovf_q;
   assign bus.sat_flag        = sat_q;
endmodule

// File: tb/tb_multi_coupling_estimator.sv
// Directed bench for multi_coupling_estimator: default instance (a) and a
// narrow instance (b: OUT_W=8, MAX_NEIGH=4) for force-close and clamp cases.
module tb_multi_coupling_estimator;
   logic clk = 1'b0;
   logic reset;
   logic ena_a, ena_b;
   int   n_cmp = 0;
   int   n_err = 0;

   int   qa_g[$], qa_h[$], qb_g[$], qb_h[$];
   bit   en_a_edge = 1'b0, en_b_edge = 1'b0;

   always #5 clk = ~clk;

   multi_coupling_estimator_if #(.PHASE_W(6), .COEF_W(4), .OUT_W(16)) ifa ();
   multi_coupling_estimator_if #(.PHASE_W(6), .COEF_W(4), .OUT_W(8))  ifb ();

   multi_coupling_estimator #(.PHASE_W(6), .COEF_W(4), .OUT_W(16), .MAX_NEIGH(8)) dut_a (
      .clk(clk), .reset(reset), .ena(ena_a), .bus(ifa));
   multi_coupling_estimator #(.PHASE_W(6), .COEF_W(4), .OUT_W(8), .MAX_NEIGH(4)) dut_b (
      .clk(clk), .reset(reset), .ena(ena_b), .bus(ifb));

   // Record each result pulse once (a held pulse during ena low is not new).
   always @(posedge clk) begin
      en_a_edge <= ena_a & ~reset;
      en_b_edge <= ena_b & ~reset;
   end
   always @(negedge clk) begin
      if (en_a_edge && ifa.out_valid) begin
         qa_g.push_back(int'(ifa.out_gradient));
         qa_h.push_back(int'(ifa.out_Hamiltonian));
      end
      if (en_b_edge && ifb.out_valid) begin
         qb_g.push_back(int'(ifb.out_gradient));
         qb_h.push_back(int'(ifb.out_Hamiltonian));
      end
   end

   typedef struct {
      int self_p;
      int coup;
      int j;
      int g;
      int h;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic beat(input bit sel, input int sp, input int cp, input int j, input bit last);
      if (!sel) begin
         ifa.in_valid = 1'b1; ifa.in_last = last;
         ifa.self_phase = 6'(sp); ifa.coupling_phase = 6'(cp); ifa.coupling_factor = 4'(j);
      end else begin
         ifb.in_valid = 1'b1; ifb.in_last = last;
         ifb.self_phase = 6'(sp); ifb.coupling_phase = 6'(cp); ifb.coupling_factor = 4'(j);
      end
      @(posedge clk); #1;
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
   endtask

   task automatic get_res(input bit sel, input string nm, output int g, output int h);
      bit got = 1'b0;
      g = -99999;
      h = -99999;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (!sel && qa_g.size() > 0) begin
            g = qa_g.pop_front(); h = qa_h.pop_front(); got = 1'b1;
         end else if (sel && qb_g.size() > 0) begin
            g = qb_g.pop_front(); h = qb_h.pop_front(); got = 1'b1;
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got no out_valid expected a result pulse", nm);
      end
   endtask

   task automatic clear_q();
      qa_g.delete(); qa_h.delete(); qb_g.delete(); qb_h.delete();
   endtask

   initial begin
      int g, h;

      vecs[0] = '{21, 36,  1, -15,  -1};
      vecs[1] = '{ 5,  5,  1,   0, -16};
      vecs[2] = '{ 0,  0, -8,   0, 128};
      vecs[3] = '{16,  0,  3,  48,   0};
      vecs[4] = '{32,  0, -2,   0, -32};
      vecs[5] = '{ 0, 16,  7,-112,   0};
      vecs[6] = '{10,  0,  5,  50, -30};
      vecs[7] = '{63,  0, -1,   1,  15};

      reset = 1'b1; ena_a = 1'b1; ena_b = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.self_phase = '0;
      ifa.coupling_phase = '0; ifa.coupling_factor = '0;
      ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.self_phase = '0;
      ifb.coupling_phase = '0; ifb.coupling_factor = '0;

      // Reset state.
      @(posedge clk); @(posedge clk); #1;
      chk("rst in_ready", int'(ifa.in_ready), 0);
      chk("rst out_valid", int'(ifa.out_valid), 0);
      chk("rst gradient", int'(ifa.out_gradient), 0);
      chk("rst overflow", int'(ifb.overflow_flag), 0);
      reset = 1'b0;
      #1;
      chk("in_ready after reset", int'(ifa.in_ready), 1);

      // Single beat with latency check.
      clear_q();
      beat(0, 21, 36, 1, 1);
      chk("t1 valid edge0", int'(ifa.out_valid), 0);
      @(posedge clk); #1;
      chk("t1 valid edge1", int'(ifa.out_valid), 0);
      @(posedge clk); #1;
      chk("t1 valid edge2", int'(ifa.out_valid), 1);
      chk("t1 gradient", int'(ifa.out_gradient), -15);
      chk("t1 hamiltonian", int'(ifa.out_Hamiltonian), -1);
      @(posedge clk); #1;
      chk("t1 pulse width", int'(ifa.out_valid), 0);
      chk("t1 gradient hold", int'(ifa.out_gradient), -15);
      repeat (2) @(posedge clk);
      #1;
      clear_q();

      // Single-beat frame table.
      for (int i = 0; i < 8; i++) begin
         beat(0, vecs[i].self_p, vecs[i].coup, vecs[i].j, 1);
         get_res(0, $sformatf("vec%0d", i), g, h);
         chk($sformatf("vec%0d gradient", i), g, vecs[i].g);
         chk($sformatf("vec%0d hamiltonian", i), h, vecs[i].h);
      end
      repeat (4) @(posedge clk);
      #1;
      clear_q();

      // Three-beat frame; later self_phase values must be ignored.
      beat(0, 8, 0, 1, 0);
      beat(0, 0, 0, 2, 0);
      beat(0, 0, 0, -1, 1);
      get_res(0, "t2", g, h);
      chk("t2 gradient", g, 16);
      chk("t2 hamiltonian", h, -16);
      repeat (6) @(negedge clk);
      chk("t2 single pulse", qa_g.size(), 0);

      // Back-to-back frames.
      beat(0, 5, 5, 1, 1);
      beat(0, 21, 36, 1, 1);
      get_res(0, "t3a", g, h);
      chk("t3a gradient", g, 0);
      chk("t3a hamiltonian", h, -16);
      get_res(0, "t3b", g, h);
      chk("t3b gradient", g, -15);
      chk("t3b hamiltonian", h, -1);
      repeat (4) @(posedge clk);
      #1;
      clear_q();

      // MAX_NEIGH=4: in_last on beat 4 is a normal close.
      for (int i = 0; i < 4; i++) beat(1, 0, 0, 1, i == 3);
      get_res(1, "t4 normal", g, h);
      chk("t4 normal hamiltonian", h, -64);
      chk("t4 normal overflow", int'(ifb.overflow_flag), 0);
      // Force-close at beat 4; beat 5 opens a new frame with its own self phase.
      for (int i = 0; i < 4; i++) beat(1, 0, 0, 1, 0);
      beat(1, 16, 0, 1, 0);
      beat(1, 0, 0, 1, 1);
      get_res(1, "t4 forced", g, h);
      chk("t4 forced gradient", g, 0);
      chk("t4 forced hamiltonian", h, -64);
      chk("t4 overflow", int'(ifb.overflow_flag), 1);
      get_res(1, "t4 next", g, h);
      chk("t4 next gradient", g, 32);
      chk("t4 next hamiltonian", h, 0);

      // Accumulator overflow at OUT_W=8.
      beat(1, 16, 0, 7, 0);
      beat(1, 16, 0, 7, 1);
      get_res(1, "t5", g, h);
      chk("t5 hamiltonian", h, 0);
`ifdef MULTI_COUPLING_ESTIMATOR_SAT_EN
      chk("t5 gradient", g, 127);
      chk("t5 sat_flag", int'(ifb.sat_flag), 1);
`else
      chk("t5 gradient", g, -32);
      chk("t5 sat_flag", int'(ifb.sat_flag), 0);
`endif
      repeat (4) @(posedge clk);
      #1;
      clear_q();

      // ena low mid-frame freezes the block; offered beats are not taken.
      beat(0, 8, 0, 1, 0);
      beat(0, 0, 0, 2, 0);
      ena_a = 1'b0;
      ifa.in_valid = 1'b1; ifa.coupling_phase = 6'd33; ifa.coupling_factor = 4'd5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("t6 in_ready low %0d", i), int'(ifa.in_ready), 0);
         chk($sformatf("t6 gradient frozen %0d", i), int'(ifa.out_gradient), -15);
         chk($sformatf("t6 valid frozen %0d", i), int'(ifa.out_valid), 0);
      end
      ifa.in_valid = 1'b0;
      ena_a = 1'b1;
      beat(0, 0, 0, -1, 1);
      get_res(0, "t6 resume", g, h);
      chk("t6 resume gradient", g, 16);
      chk("t6 resume hamiltonian", h, -16);
      repeat (4) @(posedge clk);
      #1;
      clear_q();

      // Reset mid-frame discards the partial frame.
      beat(0, 8, 0, 3, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t6 rst gradient", int'(ifa.out_gradient), 0);
      chk("t6 rst hamiltonian", int'(ifa.out_Hamiltonian), 0);
      chk("t6 rst out_valid", int'(ifa.out_valid), 0);
      chk("t6 rst in_ready", int'(ifa.in_ready), 0);
      chk("t6 rst overflow", int'(ifb.overflow_flag), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6 no discarded pulse", qa_g.size(), 0);
      #1;
      beat(0, 0, 0, 1, 1);
      get_res(0, "t6 post reset", g, h);
      chk("t6 post reset gradient", g, 0);
      chk("t6 post reset hamiltonian", h, -16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
